// File: rtl/miriscv_memory_stage.sv
// miriscv pipeline stage 4: data-bus load/store access, load alignment, GPR writeback
// select and branch/jump misprediction resolution.

package miriscv_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned WB_SRC_W   = 2;

  localparam logic [WB_SRC_W-1:0] WB_SRC_ALU = 2'd0;
  localparam logic [WB_SRC_W-1:0] WB_SRC_MDU = 2'd1;
  localparam logic [WB_SRC_W-1:0] WB_SRC_LSU = 2'd2;
endpackage

package miriscv_lsu_pkg;
  localparam int unsigned MEM_ACCESS_W = 3;

  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd3;
  localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;
endpackage

module miriscv_memory_stage
  import miriscv_pkg::*;
  import miriscv_lsu_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arstn_i,

  input  logic                    cu_kill_m_i,
  input  logic                    cu_stall_m_i,
  output logic                    m_stall_req_o,

  input  logic                    e_valid_i,
  input  logic [XLEN-1:0]         e_alu_result_i,
  input  logic [XLEN-1:0]         e_mdu_result_i,
  input  logic                    e_mem_req_i,
  input  logic                    e_mem_we_i,
  input  logic [MEM_ACCESS_W-1:0] e_mem_size_i,
  input  logic [XLEN-1:0]         e_mem_addr_i,
  input  logic [XLEN-1:0]         e_mem_data_i,
  input  logic                    e_gpr_wr_en_i,
  input  logic [GPR_ADDR_W-1:0]   e_gpr_wr_addr_i,
  input  logic [WB_SRC_W-1:0]     e_gpr_src_sel_i,
  input  logic                    e_branch_i,
  input  logic                    e_jal_i,
  input  logic                    e_jalr_i,
  input  logic                    e_prediction_i,
  input  logic                    e_br_j_taken_i,
  input  logic [XLEN-1:0]         e_target_pc_i,
  input  logic [XLEN-1:0]         e_next_pc_i,

  output logic                    data_req_o,
  output logic                    data_we_o,
  output logic [3:0]              data_be_o,
  output logic [XLEN-1:0]         data_addr_o,
  output logic [XLEN-1:0]         data_wdata_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,

  output logic                    m_flush_o,
  output logic [XLEN-1:0]         m_redirect_pc_o,
  output logic                    m_misalign_o,
  output logic                    m_valid_o,
  output logic                    m_gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_o,
  output logic [XLEN-1:0]         m_gpr_wr_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP
  } state_e;

  state_e state_q, state_d;

  // Bus request attributes captured on the first request cycle
  logic [XLEN-1:0]         addr_q;
  logic [3:0]              be_q;
  logic [XLEN-1:0]         wdata_q;
  logic                    we_q;
  logic [MEM_ACCESS_W-1:0] size_q;
  logic [1:0]              off_q;

  // Completed load waiting for the pipeline register, and a kill waiting for the drain
  logic                    held_q, held_d;
  logic [XLEN-1:0]         lsu_data_q;
  logic                    kill_pend_q, kill_pend_d;

  logic                    m_valid_q;
  logic                    m_wr_en_q;
  logic [GPR_ADDR_W-1:0]   m_wr_addr_q;
  logic [XLEN-1:0]         m_wr_data_q;
  logic                    m_misalign_q;

  logic [1:0]              off_c;
  logic [3:0]              be_c;
  logic [XLEN-1:0]         wdata_c;
  logic                    size_misal;
  logic                    misalign;
  logic                    access;
  logic                    in_idle;
  logic                    rsp_done;
  logic                    adv;
  logic                    killed;
  logic                    wr_en_c;
  logic                    ctrl;
  logic [XLEN-1:0]         lsu_data;
  logic [XLEN-1:0]         wb_data;

  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0]         rdata,
                                                 input logic [MEM_ACCESS_W-1:0] size,
                                                 input logic [1:0]              off);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      MEM_ACCESS_BYTE:  return {{24{sh[7]}}, sh[7:0]};
      MEM_ACCESS_UBYTE: return {24'd0, sh[7:0]};
      MEM_ACCESS_HALF:  return {{16{sh[15]}}, sh[15:0]};
      MEM_ACCESS_UHALF: return {16'd0, sh[15:0]};
      default:          return sh;
    endcase
  endfunction

  assign off_c = e_mem_addr_i[1:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise the
    // unlisted case arms would have to remember the old value and a latch is inferred.
    be_c       = 4'b0001 << off_c;
    size_misal = 1'b0;
    case (e_mem_size_i)
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: begin
        be_c       = 4'b0011 << off_c;
        size_misal = off_c[0];
      end
      MEM_ACCESS_WORD: begin
        be_c       = 4'hF;
        size_misal = |off_c;
      end
      default: ;
    endcase
  end

  assign wdata_c  = e_mem_data_i << {off_c, 3'b000};
  assign misalign = e_valid_i & e_mem_req_i & size_misal;
  assign access   = e_valid_i & e_mem_req_i & ~size_misal & ~cu_kill_m_i & ~held_q;
  assign in_idle  = (state_q == ST_IDLE);
  assign rsp_done = (state_q == ST_RSP) & data_rvalid_i;

  assign m_stall_req_o = (in_idle & access) | (state_q == ST_REQ)
                       | ((state_q == ST_RSP) & ~data_rvalid_i);
  assign adv           = ~cu_stall_m_i & ~m_stall_req_o;
  assign killed        = cu_kill_m_i | kill_pend_q;

  assign data_req_o   = (in_idle & access) | (state_q == ST_REQ);
  assign data_addr_o  = in_idle ? {e_mem_addr_i[XLEN-1:2], 2'b00} : addr_q;
  assign data_be_o    = in_idle ? be_c         : be_q;
  assign data_wdata_o = in_idle ? wdata_c      : wdata_q;
  assign data_we_o    = in_idle ? e_mem_we_i   : we_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (access)        state_d = data_gnt_i ? ST_RSP : ST_REQ;
      ST_REQ:  if (data_gnt_i)    state_d = ST_RSP;
      ST_RSP:  if (data_rvalid_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    held_d = held_q;
    if (adv)           held_d = 1'b0;
    else if (rsp_done) held_d = 1'b1;

    kill_pend_d = kill_pend_q;
    if (adv)                                  kill_pend_d = 1'b0;
    else if (cu_kill_m_i & (~in_idle | held_q)) kill_pend_d = 1'b1;
  end

  // Stores and misaligned accesses never write a GPR
  assign wr_en_c = e_valid_i & e_gpr_wr_en_i & ~(e_mem_req_i & (e_mem_we_i | size_misal));

  always_comb begin
    lsu_data = held_q ? lsu_data_q : align_load(data_rdata_i, size_q, off_q);
    case (e_gpr_src_sel_i)
      WB_SRC_LSU: wb_data = lsu_data;
      WB_SRC_MDU: wb_data = e_mdu_result_i;
      default:    wb_data = e_alu_result_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers regardless of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= MEM_ACCESS_WORD;
      off_q       <= '0;
      held_q      <= 1'b0;
      lsu_data_q  <= '0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      kill_pend_q <= kill_pend_d;
      if (in_idle & access) begin
        addr_q  <= {e_mem_addr_i[XLEN-1:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
        we_q    <= e_mem_we_i;
        size_q  <= e_mem_size_i;
        off_q   <= off_c;
      end
      if (rsp_done) lsu_data_q <= align_load(data_rdata_i, size_q, off_q);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_valid_q    <= 1'b0;
      m_wr_en_q    <= 1'b0;
      m_wr_addr_q  <= '0;
      m_wr_data_q  <= '0;
      m_misalign_q <= 1'b0;
    end else if (adv) begin
      m_valid_q    <= e_valid_i & ~killed;
      m_wr_en_q    <= wr_en_c & ~killed;
      m_wr_addr_q  <= e_gpr_wr_addr_i;
      m_wr_data_q  <= wb_data;
      m_misalign_q <= misalign & ~killed;
    end else begin
      m_misalign_q <= 1'b0;
      if (cu_kill_m_i) begin
        m_valid_q <= 1'b0;
        m_wr_en_q <= 1'b0;
      end
    end
  end

  assign m_valid_o       = m_valid_q;
  assign m_gpr_wr_en_o   = m_wr_en_q;
  assign m_gpr_wr_addr_o = m_wr_addr_q;
  assign m_gpr_wr_data_o = m_wr_data_q;
  assign m_misalign_o    = m_misalign_q;

  // A control transfer mispredicts on direction, and an indirect jump always redirects
  assign ctrl            = e_branch_i | e_jal_i | e_jalr_i;
  assign m_flush_o       = e_valid_i & ~cu_kill_m_i & ~m_stall_req_o & ctrl
                         & ((e_br_j_taken_i != e_prediction_i) | (e_jalr_i & e_br_j_taken_i));
  assign m_redirect_pc_o = e_br_j_taken_i ? e_target_pc_i : e_next_pc_i;

endmodule

// File: tb/tb_miriscv_memory_stage.sv
// Scoreboard bench for miriscv_memory_stage: drivers push expected writebacks, a monitor
// pops and compares each time the pipeline register takes a valid instruction.

module tb_miriscv_memory_stage;
  import miriscv_pkg::*;
  import miriscv_lsu_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    arstn_i = 1'b0;
  logic                    cu_kill_m_i, cu_stall_m_i, m_stall_req_o;
  logic                    e_valid_i;
  logic [XLEN-1:0]         e_alu_result_i, e_mdu_result_i;
  logic                    e_mem_req_i, e_mem_we_i;
  logic [MEM_ACCESS_W-1:0] e_mem_size_i;
  logic [XLEN-1:0]         e_mem_addr_i, e_mem_data_i;
  logic                    e_gpr_wr_en_i;
  logic [GPR_ADDR_W-1:0]   e_gpr_wr_addr_i;
  logic [WB_SRC_W-1:0]     e_gpr_src_sel_i;
  logic                    e_branch_i, e_jal_i, e_jalr_i, e_prediction_i, e_br_j_taken_i;
  logic [XLEN-1:0]         e_target_pc_i, e_next_pc_i;
  logic                    data_req_o, data_we_o;
  logic [3:0]              data_be_o;
  logic [XLEN-1:0]         data_addr_o, data_wdata_o;
  logic                    data_gnt_i, data_rvalid_i;
  logic [XLEN-1:0]         data_rdata_i;
  logic                    m_flush_o;
  logic [XLEN-1:0]         m_redirect_pc_o;
  logic                    m_misalign_o, m_valid_o, m_gpr_wr_en_o;
  logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_o;
  logic [XLEN-1:0]         m_gpr_wr_data_o;

  miriscv_memory_stage dut (
    .clk_i           (clk_i),
    .arstn_i         (arstn_i),
    .cu_kill_m_i     (cu_kill_m_i),
    .cu_stall_m_i    (cu_stall_m_i),
    .m_stall_req_o   (m_stall_req_o),
    .e_valid_i       (e_valid_i),
    .e_alu_result_i  (e_alu_result_i),
    .e_mdu_result_i  (e_mdu_result_i),
    .e_mem_req_i     (e_mem_req_i),
    .e_mem_we_i      (e_mem_we_i),
    .e_mem_size_i    (e_mem_size_i),
    .e_mem_addr_i    (e_mem_addr_i),
    .e_mem_data_i    (e_mem_data_i),
    .e_gpr_wr_en_i   (e_gpr_wr_en_i),
    .e_gpr_wr_addr_i (e_gpr_wr_addr_i),
    .e_gpr_src_sel_i (e_gpr_src_sel_i),
    .e_branch_i      (e_branch_i),
    .e_jal_i         (e_jal_i),
    .e_jalr_i        (e_jalr_i),
    .e_prediction_i  (e_prediction_i),
    .e_br_j_taken_i  (e_br_j_taken_i),
    .e_target_pc_i   (e_target_pc_i),
    .e_next_pc_i     (e_next_pc_i),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_gnt_i      (data_gnt_i),
    .data_rvalid_i   (data_rvalid_i),
    .data_rdata_i    (data_rdata_i),
    .m_flush_o       (m_flush_o),
    .m_redirect_pc_o (m_redirect_pc_o),
    .m_misalign_o    (m_misalign_o),
    .m_valid_o       (m_valid_o),
    .m_gpr_wr_en_o   (m_gpr_wr_en_o),
    .m_gpr_wr_addr_o (m_gpr_wr_addr_o),
    .m_gpr_wr_data_o (m_gpr_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        valid;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        misal;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    cu_kill_m_i     = 1'b0;
    cu_stall_m_i    = 1'b0;
    e_valid_i       = 1'b0;
    e_alu_result_i  = '0;
    e_mdu_result_i  = '0;
    e_mem_req_i     = 1'b0;
    e_mem_we_i      = 1'b0;
    e_mem_size_i    = MEM_ACCESS_WORD;
    e_mem_addr_i    = '0;
    e_mem_data_i    = '0;
    e_gpr_wr_en_i   = 1'b0;
    e_gpr_wr_addr_i = '0;
    e_gpr_src_sel_i = WB_SRC_ALU;
    e_branch_i      = 1'b0;
    e_jal_i         = 1'b0;
    e_jalr_i        = 1'b0;
    e_prediction_i  = 1'b0;
    e_br_j_taken_i  = 1'b0;
    e_target_pc_i   = '0;
    e_next_pc_i     = '0;
  endtask

  // Monitor: an instruction is taken when the pipe advances with e_valid_i high
  initial begin : monitor
    bit   pending;
    exp_t e;
    pending = 1'b0;
    forever begin
      @(negedge clk_i);
      if (pending) begin
        pending = 1'b0;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got writeback valid=%0b expected no transaction", m_valid_o);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_valid"}, 32'(m_valid_o), 32'(e.valid));
          check({e.name, "_wr_en"}, 32'(m_gpr_wr_en_o), 32'(e.wr_en));
          if (e.wr_en) begin
            check({e.name, "_wr_addr"}, 32'(m_gpr_wr_addr_o), 32'(e.addr));
            check({e.name, "_wr_data"}, m_gpr_wr_data_o, e.data);
          end
          check({e.name, "_misalign"}, 32'(m_misalign_o), 32'(e.misal));
        end
      end
      if (arstn_i && !cu_stall_m_i && !m_stall_req_o && e_valid_i) pending = 1'b1;
    end
  end

  task automatic issue_wb(input string name, input logic [1:0] src, input logic [31:0] alu,
                          input logic [31:0] mdu, input logic [4:0] rd, input logic [31:0] exp_data);
    sb_q.push_back('{name: name, valid: 1'b1, wr_en: 1'b1, addr: rd, data: exp_data, misal: 1'b0});
    e_valid_i       = 1'b1;
    e_gpr_wr_en_i   = 1'b1;
    e_gpr_wr_addr_i = rd;
    e_gpr_src_sel_i = src;
    e_alu_result_i  = alu;
    e_mdu_result_i  = mdu;
    step();
    set_idle();
  endtask

  // Drives one aligned access; gnt arrives gnt_dly cycles after the first request and
  // rvalid rv_dly cycles after gnt. kill_at < 0 means no kill.
  task automatic issue_mem(input string name, input logic [2:0] size, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gnt_dly, input int rv_dly, input int kill_at,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data, input int exp_stall);
    int stall_cnt;
    bit done;
    bit killed;
    killed = (kill_at >= 0);
    sb_q.push_back('{name: name, valid: !killed, wr_en: !we && !killed, addr: 5'd7,
                     data: exp_data, misal: 1'b0});
    e_valid_i       = 1'b1;
    e_mem_req_i     = 1'b1;
    e_mem_we_i      = we;
    e_mem_size_i    = size;
    e_gpr_wr_en_i   = 1'b1;
    e_gpr_wr_addr_i = 5'd7;
    e_gpr_src_sel_i = WB_SRC_LSU;
    e_alu_result_i  = 32'h5555_5555;
    stall_cnt = 0;
    done      = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      e_mem_addr_i  = (c == 0) ? addr : {~addr[31:2], addr[1:0]};
      e_mem_data_i  = (c == 0) ? wdata : ~wdata;
      data_gnt_i    = (c == gnt_dly);
      data_rvalid_i = (c == gnt_dly + rv_dly);
      data_rdata_i  = data_rvalid_i ? rdata : 32'hDEAD_BEEF;
      cu_kill_m_i   = (c == kill_at);
      @(negedge clk_i);
      if (m_stall_req_o) stall_cnt++;
      if (c == gnt_dly) begin
        check({name, "_req"},   32'(data_req_o), 32'd1);
        check({name, "_we"},    32'(data_we_o), 32'(we));
        check({name, "_be"},    32'(data_be_o), 32'(exp_be));
        check({name, "_addr"},  data_addr_o, {addr[31:2], 2'b00});
        check({name, "_wdata"}, data_wdata_o, exp_wdata);
      end
      if (c == gnt_dly + 1) check({name, "_req_drop"}, 32'(data_req_o), 32'd0);
      if (data_rvalid_i) done = 1'b1;
      step();
    end
    set_idle();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic issue_misal(input string name, input logic [2:0] size, input logic [31:0] addr);
    sb_q.push_back('{name: name, valid: 1'b1, wr_en: 1'b0, addr: 5'd5, data: 32'd0, misal: 1'b1});
    e_valid_i       = 1'b1;
    e_mem_req_i     = 1'b1;
    e_mem_size_i    = size;
    e_mem_addr_i    = addr;
    e_gpr_wr_en_i   = 1'b1;
    e_gpr_wr_addr_i = 5'd5;
    e_gpr_src_sel_i = WB_SRC_LSU;
    @(negedge clk_i);
    check({name, "_no_req"},   32'(data_req_o), 32'd0);
    check({name, "_no_stall"}, 32'(m_stall_req_o), 32'd0);
    step();
    set_idle();
    @(negedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check({name, "_pulse_end"}, 32'(m_misalign_o), 32'd0);
    #1;
  endtask

  task automatic issue_br(input string name, input logic br, input logic jal, input logic jalr,
                          input logic pred, input logic taken, input logic [31:0] target,
                          input logic [31:0] next_pc, input logic kill, input logic exp_flush,
                          input logic [31:0] exp_pc);
    sb_q.push_back('{name: name, valid: !kill, wr_en: 1'b0, addr: 5'd0, data: 32'd0, misal: 1'b0});
    e_valid_i      = 1'b1;
    e_branch_i     = br;
    e_jal_i        = jal;
    e_jalr_i       = jalr;
    e_prediction_i = pred;
    e_br_j_taken_i = taken;
    e_target_pc_i  = target;
    e_next_pc_i    = next_pc;
    cu_kill_m_i    = kill;
    @(negedge clk_i);
    check({name, "_flush"}, 32'(m_flush_o), 32'(exp_flush));
    check({name, "_redirect"}, m_redirect_pc_o, exp_pc);
    step();
    set_idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    set_idle();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    arstn_i       = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid",    32'(m_valid_o), 32'd0);
    check("rst_wr_en",    32'(m_gpr_wr_en_o), 32'd0);
    check("rst_wr_addr",  32'(m_gpr_wr_addr_o), 32'd0);
    check("rst_wr_data",  m_gpr_wr_data_o, 32'd0);
    check("rst_req",      32'(data_req_o), 32'd0);
    check("rst_stall",    32'(m_stall_req_o), 32'd0);
    check("rst_flush",    32'(m_flush_o), 32'd0);
    check("rst_misalign", 32'(m_misalign_o), 32'd0);
    step();
    arstn_i = 1'b1;
    step();

    // Writeback source selection and pipeline hold
    issue_wb("add_alu", WB_SRC_ALU, 32'h1111_0000, 32'hBAD0_0000, 5'd3, 32'h1111_0000);
    sb_q.push_back('{name: "add_held", valid: 1'b1, wr_en: 1'b1, addr: 5'd4,
                     data: 32'h2222_2222, misal: 1'b0});
    e_valid_i       = 1'b1;
    e_gpr_wr_en_i   = 1'b1;
    e_gpr_wr_addr_i = 5'd4;
    e_gpr_src_sel_i = WB_SRC_ALU;
    e_alu_result_i  = 32'h2222_2222;
    cu_stall_m_i    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("hold_data", m_gpr_wr_data_o, 32'h1111_0000);
      check("hold_addr", 32'(m_gpr_wr_addr_o), 32'd3);
      step();
    end
    cu_stall_m_i = 1'b0;
    step();
    set_idle();
    issue_wb("mul_mdu", WB_SRC_MDU, 32'h0000_0001, 32'h0BAD_F00D, 5'd9, 32'h0BAD_F00D);

    // Loads and stores: name size we addr wdata rdata gnt rv kill be wdata data stalls
    issue_mem("lb_103",  MEM_ACCESS_BYTE,  1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456,
              0, 1, -1, 4'b1000, 32'h0, 32'hFFFF_FF80, 1);
    issue_mem("sh_102",  MEM_ACCESS_HALF,  1'b1, 32'h0000_0102, 32'h0000_ABCD, 32'h0,
              3, 1, -1, 4'b1100, 32'hABCD_0000, 32'h0, 4);
    issue_mem("lhu_102", MEM_ACCESS_UHALF, 1'b0, 32'h0000_0102, 32'h0, 32'h8765_4321,
              0, 1, -1, 4'b1100, 32'h0, 32'h0000_8765, 1);
    issue_mem("lh_100",  MEM_ACCESS_HALF,  1'b0, 32'h0000_0100, 32'h0, 32'h1234_F00D,
              0, 1, -1, 4'b0011, 32'h0, 32'hFFFF_F00D, 1);
    issue_mem("lbu_101", MEM_ACCESS_UBYTE, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_9A78,
              0, 1, -1, 4'b0010, 32'h0, 32'h0000_009A, 1);
    issue_mem("lw_104",  MEM_ACCESS_WORD,  1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D,
              1, 2, -1, 4'b1111, 32'h0, 32'hCAFE_F00D, 3);
    issue_mem("sb_101",  MEM_ACCESS_BYTE,  1'b1, 32'h0000_0101, 32'h0000_00EE, 32'h0,
              0, 1, -1, 4'b0010, 32'h0000_EE00, 32'h0, 1);
    issue_mem("lw_kill", MEM_ACCESS_WORD,  1'b0, 32'h0000_0108, 32'h0, 32'h1357_9BDF,
              0, 3, 1, 4'b1111, 32'h0, 32'h0, 3);

    issue_misal("lw_misal", MEM_ACCESS_WORD, 32'h0000_0101);
    issue_misal("lh_misal", MEM_ACCESS_HALF, 32'h0000_0103);

    // Control transfers: name br jal jalr pred taken target next kill flush pc
    issue_br("beq_mispred", 1, 0, 0, 0, 1, 32'h200, 32'h104, 0, 1, 32'h200);
    issue_br("beq_ok",      1, 0, 0, 1, 1, 32'h200, 32'h104, 0, 0, 32'h200);
    issue_br("bne_nt",      1, 0, 0, 1, 0, 32'h300, 32'h108, 0, 1, 32'h108);
    issue_br("jal_ok",      0, 1, 0, 1, 1, 32'h400, 32'h10C, 0, 0, 32'h400);
    issue_br("jalr",        0, 0, 1, 1, 1, 32'h500, 32'h110, 0, 1, 32'h500);
    issue_br("beq_killed",  1, 0, 0, 0, 1, 32'h600, 32'h114, 1, 0, 32'h600);
    issue_br("non_ctrl",    0, 0, 0, 0, 1, 32'h700, 32'h118, 0, 0, 32'h700);

    // Reset while a request waits for grant; a late rvalid must be ignored afterwards
    e_valid_i       = 1'b1;
    e_mem_req_i     = 1'b1;
    e_mem_size_i    = MEM_ACCESS_WORD;
    e_mem_addr_i    = 32'h0000_0110;
    e_gpr_wr_en_i   = 1'b1;
    e_gpr_wr_addr_i = 5'd8;
    e_gpr_src_sel_i = WB_SRC_LSU;
    step();
    check("rstmid_req_held", 32'(data_req_o), 32'd1);
    arstn_i = 1'b0;
    set_idle();
    #1;
    check("rstmid_req_drop",   32'(data_req_o), 32'd0);
    check("rstmid_stall_drop", 32'(m_stall_req_o), 32'd0);
    step();
    arstn_i       = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("late_rvalid_stall", 32'(m_stall_req_o), 32'd0);
    check("late_rvalid_req",   32'(data_req_o), 32'd0);
    step();
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("late_rvalid_valid", 32'(m_valid_o), 32'd0);

    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
